// File: rtl/pattern_pkg.sv
// Shared definitions for the test-pattern generator: pattern select codes
// and the packed pixel type used at the video interface.
package pattern_pkg;

    localparam int PKG_COLOR_W = 8;

    typedef enum logic [1:0] {
        MODE_BARS  = 2'd0,
        MODE_CHECK = 2'd1,
        MODE_RAMP  = 2'd2,
        MODE_SOLID = 2'd3
    } mode_e;

    typedef struct packed {
        logic [PKG_COLOR_W-1:0] r;
        logic [PKG_COLOR_W-1:0] g;
        logic [PKG_COLOR_W-1:0] b;
    } rgb_t;

endpackage

// File: rtl/pattern_line_counter.sv
// Positional per-line counters: colour-bar index and horizontal grey ramp.
// Both restart whenever data_en is low, so they never depend on column.
module pattern_line_counter
    import pattern_pkg::*;
#(
    parameter int COORD_W  = 11,
    parameter int COLOR_W  = 8,
    parameter int H_ACTIVE = 1280,
    parameter int NUM_BARS = 8,
    parameter int GRAD_DIV = 5
) (
    input  logic               pix_clk,
    input  logic               resetn,
    input  logic               data_en,
    output logic [2:0]         bar_idx,
    output logic [COLOR_W-1:0] ramp
);

    localparam int BAR_W = H_ACTIVE / NUM_BARS;
    localparam int DIV_W = $clog2(GRAD_DIV) + 1;
    localparam logic [COORD_W-1:0] BAR_PX_LAST = COORD_W'(BAR_W - 1);
    localparam logic [DIV_W-1:0]   DIV_LAST    = DIV_W'(GRAD_DIV - 1);
    localparam logic [2:0]         BAR_LAST    = 3'(NUM_BARS - 1);

    logic [COORD_W-1:0] bar_px;
    logic [DIV_W-1:0]   div_cnt;

    function automatic logic [2:0] sat_bar(input logic [2:0] v);
        return (v == BAR_LAST) ? v : v + 3'd1;
    endfunction

    function automatic logic [COLOR_W-1:0] sat_ramp(input logic [COLOR_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Counters advance once per active pixel; overlong lines saturate.
    always_ff @(posedge pix_clk or negedge resetn) begin
        if (!resetn) begin
            bar_px  <= '0;
            bar_idx <= '0;
            div_cnt <= '0;
            ramp    <= '0;
        end else if (!data_en) begin
            bar_px  <= '0;
            bar_idx <= '0;
            div_cnt <= '0;
            ramp    <= '0;
        end else begin
            if (bar_px == BAR_PX_LAST) begin
                bar_px  <= '0;
                bar_idx <= sat_bar(bar_idx);
            end else begin
                bar_px <= bar_px + 1'b1;
            end
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                ramp    <= sat_ramp(ramp);
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pattern_gen.sv
// Run-time selectable video test patterns (bars, checker, ramp, solid) with
// one-cycle registered RGB and re-timed sync; mode changes land on vsync.
module pattern_gen
    import pattern_pkg::*;
#(
    parameter int COORD_W    = 11,
    parameter int COLOR_W    = 8,
    parameter int H_ACTIVE   = 1280,
    parameter int NUM_BARS   = 8,
    parameter int CHECK_LOG2 = 5,
    parameter int GRAD_DIV   = 5,
    parameter bit ANIMATE    = 1'b1,
    parameter int FLIP_LOG2  = 5,
    parameter bit VSYNC_POL  = 1'b1
) (
    input  logic                 pix_clk,
    input  logic                 resetn,
    input  logic [COORD_W-1:0]   column,
    input  logic [COORD_W-1:0]   row,
    input  logic                 data_en,
    input  logic                 hsync,
    input  logic                 vsync,
    input  logic [1:0]           mode,
    input  logic [3*COLOR_W-1:0] solid_rgb,
    output logic [COLOR_W-1:0]   red,
    output logic [COLOR_W-1:0]   green,
    output logic [COLOR_W-1:0]   blue,
    output logic                 data_en_o,
    output logic                 hsync_o,
    output logic                 vsync_o,
    output logic [7:0]           frame_cnt
);

    typedef struct packed {
        logic [COLOR_W-1:0] r;
        logic [COLOR_W-1:0] g;
        logic [COLOR_W-1:0] b;
    } pix_t;

    localparam int BAR_SHIFT = 3 - $clog2(NUM_BARS);

    mode_e                mode_q;
    logic [3*COLOR_W-1:0] solid_q;
    logic [2:0]           bar_idx;
    logic [COLOR_W-1:0]   ramp;
    logic [2:0]           bar_code_p0;
    logic                 chk_p0;
    logic                 frame_evt_p0;
    pix_t                 pix_p0;
    logic                 unused_coord;

    // Only one bit of each coordinate feeds the checker.
    assign unused_coord = ^{column, row};

    pattern_line_counter #(
        .COORD_W  (COORD_W),
        .COLOR_W  (COLOR_W),
        .H_ACTIVE (H_ACTIVE),
        .NUM_BARS (NUM_BARS),
        .GRAD_DIV (GRAD_DIV)
    ) u_line_counter (
        .pix_clk (pix_clk),
        .resetn  (resetn),
        .data_en (data_en),
        .bar_idx (bar_idx),
        .ramp    (ramp)
    );

    // Stage p0: vsync_o doubles as the previous vsync sample.
    assign frame_evt_p0 = (vsync_o != VSYNC_POL) && (vsync == VSYNC_POL);
    assign bar_code_p0  = 3'(bar_idx << BAR_SHIFT);
    assign chk_p0       = column[CHECK_LOG2] ^ row[CHECK_LOG2] ^ (ANIMATE & frame_cnt[FLIP_LOG2]);

    always_comb begin
        pix_p0 = '0;
        case (mode_q)
            MODE_BARS: begin
                pix_p0.r = {COLOR_W{bar_code_p0[2]}};
                pix_p0.g = {COLOR_W{bar_code_p0[1]}};
                pix_p0.b = {COLOR_W{bar_code_p0[0]}};
            end
            MODE_CHECK: pix_p0 = {3*COLOR_W{chk_p0}};
            MODE_RAMP:  pix_p0 = {ramp, ramp, ramp};
            MODE_SOLID: pix_p0 = pix_t'(solid_q);
            default:    pix_p0 = '0;
        endcase
    end

    // Stage p1: registered outputs, frame-synchronous mode capture.
    always_ff @(posedge pix_clk or negedge resetn) begin
        if (!resetn) begin
            red       <= '0;
            green     <= '0;
            blue      <= '0;
            data_en_o <= 1'b0;
            hsync_o   <= 1'b0;
            vsync_o   <= 1'b0;
            frame_cnt <= '0;
            mode_q    <= MODE_BARS;
            solid_q   <= '0;
        end else begin
            data_en_o <= data_en;
            hsync_o   <= hsync;
            vsync_o   <= vsync;
            {red, green, blue} <= data_en ? pix_p0 : '0;
            if (frame_evt_p0) begin
                mode_q    <= mode_e'(mode);
                solid_q   <= solid_rgb;
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_pattern_gen.sv
// Directed bench for pattern_gen: two instances differing only in vsync
// polarity share stimulus; expected pixels are hand-computed constants.
module tb_pattern_gen;

    logic        pix_clk = 1'b0;
    logic        resetn  = 1'b0;
    logic [10:0] column  = '0;
    logic [10:0] row     = '0;
    logic        data_en = 1'b0;
    logic        hsync   = 1'b0;
    logic        vsync   = 1'b0;
    logic [1:0]  mode    = 2'd0;
    logic [23:0] solid_rgb = '0;

    logic [7:0]  red, green, blue, frame_cnt;
    logic        data_en_o, hsync_o, vsync_o;
    logic [7:0]  red_n, green_n, blue_n, frame_cnt_n;
    logic        data_en_o_n, hsync_o_n, vsync_o_n;

    int checks   = 0;
    int failures = 0;

    logic [23:0] cap_rgb [0:1399];
    logic        cap_de  [0:1399];

    always #5 pix_clk = ~pix_clk;

    pattern_gen #(.VSYNC_POL(1'b1)) u_dut (
        .pix_clk(pix_clk), .resetn(resetn), .column(column), .row(row),
        .data_en(data_en), .hsync(hsync), .vsync(vsync), .mode(mode),
        .solid_rgb(solid_rgb), .red(red), .green(green), .blue(blue),
        .data_en_o(data_en_o), .hsync_o(hsync_o), .vsync_o(vsync_o),
        .frame_cnt(frame_cnt)
    );

    pattern_gen #(.VSYNC_POL(1'b0)) u_dut_n (
        .pix_clk(pix_clk), .resetn(resetn), .column(column), .row(row),
        .data_en(data_en), .hsync(hsync), .vsync(vsync), .mode(mode),
        .solid_rgb(solid_rgb), .red(red_n), .green(green_n), .blue(blue_n),
        .data_en_o(data_en_o_n), .hsync_o(hsync_o_n), .vsync_o(vsync_o_n),
        .frame_cnt(frame_cnt_n)
    );

    task automatic tick();
        @(posedge pix_clk);
        #1;
    endtask

    task automatic run_line(input int len, input int row_v);
        data_en = 1'b1;
        row     = 11'(row_v);
        for (int i = 0; i < len; i++) begin
            column = 11'(i);
            tick();
            cap_rgb[i] = {red, green, blue};
            cap_de[i]  = data_en_o;
        end
        data_en = 1'b0;
        column  = '0;
        tick();
        tick();
    endtask

    task automatic frame_pulse();
        vsync = 1'b1;
        tick();
        tick();
        vsync = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        data_en = 1'b1; hsync = 1'b1; vsync = 1'b1; mode = 2'd3; solid_rgb = 24'hFFFFFF;
        repeat (3) tick();
        checks++;
        if ({red, green, blue, data_en_o, hsync_o, vsync_o} !== 27'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h required=0", {red, green, blue, data_en_o, hsync_o, vsync_o});
        end
        checks++;
        if ({red_n, green_n, blue_n, data_en_o_n, hsync_o_n, vsync_o_n} !== 27'd0) begin
            failures++;
            $display("FAIL reset_outputs_n got=%h required=0", {red_n, green_n, blue_n, data_en_o_n, hsync_o_n, vsync_o_n});
        end
        checks++;
        if (frame_cnt !== 8'd0 || frame_cnt_n !== 8'd0) begin
            failures++;
            $display("FAIL reset_frame_cnt got=%0d/%0d required=0", frame_cnt, frame_cnt_n);
        end
        data_en = 1'b0; hsync = 1'b0; vsync = 1'b0; mode = 2'd0; solid_rgb = '0;
        resetn = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_bars();
        data_en = 1'b1;
        #1;
        checks++;
        if (data_en_o !== 1'b0) begin
            failures++;
            $display("FAIL de_latency_early got=%b required=0", data_en_o);
        end
        tick();
        checks++;
        if (data_en_o !== 1'b1) begin
            failures++;
            $display("FAIL de_latency_one got=%b required=1", data_en_o);
        end
        data_en = 1'b0;
        tick();
        checks++;
        if (data_en_o !== 1'b0) begin
            failures++;
            $display("FAIL de_latency_fall got=%b required=0", data_en_o);
        end
        run_line(1300, 0);
        checks++;
        if (cap_rgb[0] !== 24'h000000 || cap_de[0] !== 1'b1) begin
            failures++;
            $display("FAIL bars_px0 got=%h de=%b required=000000 de=1", cap_rgb[0], cap_de[0]);
        end
        checks++;
        if (cap_rgb[159] !== 24'h000000) begin
            failures++;
            $display("FAIL bars_px159 got=%h required=000000", cap_rgb[159]);
        end
        checks++;
        if (cap_rgb[160] !== 24'h0000FF) begin
            failures++;
            $display("FAIL bars_px160 got=%h required=0000FF", cap_rgb[160]);
        end
        checks++;
        if (cap_rgb[320] !== 24'h00FF00) begin
            failures++;
            $display("FAIL bars_px320 got=%h required=00FF00", cap_rgb[320]);
        end
        checks++;
        if (cap_rgb[800] !== 24'hFF00FF) begin
            failures++;
            $display("FAIL bars_px800 got=%h required=FF00FF", cap_rgb[800]);
        end
        checks++;
        if (cap_rgb[1279] !== 24'hFFFFFF) begin
            failures++;
            $display("FAIL bars_px1279 got=%h required=FFFFFF", cap_rgb[1279]);
        end
        checks++;
        if (cap_rgb[1299] !== 24'hFFFFFF) begin
            failures++;
            $display("FAIL bars_overlong got=%h required=FFFFFF", cap_rgb[1299]);
        end
    endtask

    task automatic test_checker();
        mode = 2'd1;
        frame_pulse();
        checks++;
        if (frame_cnt !== 8'd1 || frame_cnt_n !== 8'd1) begin
            failures++;
            $display("FAIL chk_frame1 got=%0d/%0d required=1", frame_cnt, frame_cnt_n);
        end
        run_line(64, 0);
        checks++;
        if (cap_rgb[32] !== 24'hFFFFFF || cap_rgb[0] !== 24'h000000) begin
            failures++;
            $display("FAIL chk_row0 got=%h,%h required=FFFFFF,000000", cap_rgb[32], cap_rgb[0]);
        end
        run_line(64, 32);
        checks++;
        if (cap_rgb[32] !== 24'h000000 || cap_rgb[0] !== 24'hFFFFFF) begin
            failures++;
            $display("FAIL chk_row32 got=%h,%h required=000000,FFFFFF", cap_rgb[32], cap_rgb[0]);
        end
        repeat (31) frame_pulse();
        checks++;
        if (frame_cnt !== 8'd32) begin
            failures++;
            $display("FAIL chk_frame32 got=%0d required=32", frame_cnt);
        end
        run_line(64, 0);
        checks++;
        if (cap_rgb[32] !== 24'h000000) begin
            failures++;
            $display("FAIL chk_inv_row0 got=%h required=000000", cap_rgb[32]);
        end
        run_line(64, 32);
        checks++;
        if (cap_rgb[32] !== 24'hFFFFFF) begin
            failures++;
            $display("FAIL chk_inv_row32 got=%h required=FFFFFF", cap_rgb[32]);
        end
        repeat (223) frame_pulse();
        checks++;
        if (frame_cnt !== 8'd255 || frame_cnt_n !== 8'd255) begin
            failures++;
            $display("FAIL frame_255 got=%0d/%0d required=255", frame_cnt, frame_cnt_n);
        end
        frame_pulse();
        checks++;
        if (frame_cnt !== 8'd0 || frame_cnt_n !== 8'd0) begin
            failures++;
            $display("FAIL frame_wrap got=%0d/%0d required=0", frame_cnt, frame_cnt_n);
        end
    endtask

    task automatic test_ramp();
        mode = 2'd2;
        frame_pulse();
        run_line(1300, 0);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (cap_rgb[i] !== 24'h000000) begin
                failures++;
                $display("FAIL ramp_px%0d got=%h required=000000", i, cap_rgb[i]);
            end
        end
        checks++;
        if (cap_rgb[5] !== 24'h010101 || cap_rgb[9] !== 24'h010101) begin
            failures++;
            $display("FAIL ramp_step1 got=%h,%h required=010101", cap_rgb[5], cap_rgb[9]);
        end
        checks++;
        if (cap_rgb[10] !== 24'h020202) begin
            failures++;
            $display("FAIL ramp_step2 got=%h required=020202", cap_rgb[10]);
        end
        checks++;
        if (cap_rgb[1274] !== 24'hFEFEFE) begin
            failures++;
            $display("FAIL ramp_px1274 got=%h required=FEFEFE", cap_rgb[1274]);
        end
        for (int i = 1275; i < 1300; i++) begin
            checks++;
            if (cap_rgb[i] !== 24'hFFFFFF) begin
                failures++;
                $display("FAIL ramp_sat_px%0d got=%h required=FFFFFF", i, cap_rgb[i]);
            end
        end
    endtask

    task automatic test_mode_switch();
        mode = 2'd0;
        frame_pulse();
        run_line(200, 0);
        checks++;
        if (cap_rgb[160] !== 24'h0000FF) begin
            failures++;
            $display("FAIL sw_bars_before got=%h required=0000FF", cap_rgb[160]);
        end
        mode = 2'd3;
        solid_rgb = 24'h123456;
        run_line(200, 1);
        checks++;
        if (cap_rgb[0] !== 24'h000000 || cap_rgb[160] !== 24'h0000FF) begin
            failures++;
            $display("FAIL sw_held_bars got=%h,%h required=000000,0000FF", cap_rgb[0], cap_rgb[160]);
        end
        frame_pulse();
        solid_rgb = 24'h654321;
        run_line(200, 2);
        checks++;
        if (cap_rgb[0] !== 24'h123456 || cap_rgb[160] !== 24'h123456) begin
            failures++;
            $display("FAIL sw_solid got=%h,%h required=123456", cap_rgb[0], cap_rgb[160]);
        end
    endtask

    task automatic test_blank_sync();
        logic [15:0] hs_pat;
        logic [15:0] vs_pat;
        hs_pat  = 16'hB2D4;
        vs_pat  = 16'h6C39;
        data_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            hsync  = hs_pat[i];
            vsync  = vs_pat[i];
            column = 11'(i * 37);
            row    = 11'(i * 5);
            tick();
            checks++;
            if ({red, green, blue, red_n, green_n, blue_n} !== 48'd0) begin
                failures++;
                $display("FAIL blank_rgb_%0d got=%h,%h required=0", i, {red, green, blue}, {red_n, green_n, blue_n});
            end
            checks++;
            if (hsync_o !== hs_pat[i] || vsync_o !== vs_pat[i] ||
                hsync_o_n !== hs_pat[i] || vsync_o_n !== vs_pat[i]) begin
                failures++;
                $display("FAIL sync_delay_%0d got=%b%b/%b%b required=%b%b", i,
                         hsync_o, vsync_o, hsync_o_n, vsync_o_n, hs_pat[i], vs_pat[i]);
            end
        end
        hsync = 1'b0; vsync = 1'b0; column = '0; row = '0;
        repeat (2) tick();
    endtask

    task automatic test_reset_midline();
        mode = 2'd3;
        solid_rgb = 24'h123456;
        frame_pulse();
        data_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            column = 11'(i);
            tick();
        end
        checks++;
        if ({red, green, blue} !== 24'h123456) begin
            failures++;
            $display("FAIL midline_solid got=%h required=123456", {red, green, blue});
        end
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if ({red, green, blue, data_en_o, red_n, green_n, blue_n, data_en_o_n} !== 50'd0) begin
            failures++;
            $display("FAIL midline_reset_rgb got=%h required=0",
                     {red, green, blue, data_en_o, red_n, green_n, blue_n, data_en_o_n});
        end
        checks++;
        if (frame_cnt !== 8'd0 || frame_cnt_n !== 8'd0) begin
            failures++;
            $display("FAIL midline_reset_fc got=%0d/%0d required=0", frame_cnt, frame_cnt_n);
        end
        tick();
        resetn = 1'b1;
        for (int i = 20; i < 50; i++) begin
            column = 11'(i);
            tick();
        end
        checks++;
        if ({red, green, blue} !== 24'h000000) begin
            failures++;
            $display("FAIL midline_mode_bars got=%h required=000000", {red, green, blue});
        end
        data_en = 1'b0;
        tick();
        run_line(200, 1);
        checks++;
        if (cap_rgb[0] !== 24'h000000 || cap_rgb[159] !== 24'h000000 || cap_rgb[160] !== 24'h0000FF) begin
            failures++;
            $display("FAIL midline_next_line got=%h,%h,%h required=000000,000000,0000FF",
                     cap_rgb[0], cap_rgb[159], cap_rgb[160]);
        end
    endtask

    initial begin
        test_reset();
        test_bars();
        test_checker();
        test_ramp();
        test_mode_switch();
        test_blank_sync();
        test_reset_midline();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
